// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side and FIFO-push-side signals of the write-port arbiter.
// The arbiter connects through the slave modport; whatever drives the
// requesters and models the FIFO uses the master modport.
interface fifo_wr_arbiter_if #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8
);
    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ*DATA_WIDTH-1:0] req_data;
    logic [N_REQ-1:0]            req_ready;
    logic                        fifo_full;
    logic                        fifo_push;
    logic [DATA_WIDTH-1:0]       fifo_data_in;

    modport master (
        output req_valid,
        output req_data,
        output fifo_full,
        input  req_ready,
        input  fifo_push,
        input  fifo_data_in
    );

    modport slave (
        input  req_valid,
        input  req_data,
        input  fifo_full,
        output req_ready,
        output fifo_push,
        output fifo_data_in
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter sharing one FIFO push port among N_REQ
// valid/ready requesters. A grant lasts up to MAX_BURST words, ends early
// when the owner drops valid, and stalls (without timeout) while the FIFO
// is full. Every burst is preceded by one IDLE arbitration cycle.
module fifo_wr_arbiter #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    fifo_wr_arbiter_if.slave         bus,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy,
    output logic [CNT_WIDTH-1:0]     push_count
);

    localparam int GW = $clog2(N_REQ);
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [GW-1:0] LAST_REQ  = GW'(N_REQ - 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t               state_q, state_d;
    logic [GW-1:0]        grant_q, grant_d;
    logic [GW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [BW-1:0]        beat_q, beat_d;
    logic [CNT_WIDTH-1:0] push_cnt_q;

    logic                  any_valid;
    logic [GW-1:0]         winner;
    logic                  grant_valid;
    logic [DATA_WIDTH-1:0] grant_data;
    logic [GW-1:0]         next_ptr;
    logic                  in_burst;

    // Requester index 'off' positions after 'base', wrapping at N_REQ.
    function automatic logic [GW-1:0] rr_index(input logic [GW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= N_REQ) begin
            sum = sum - N_REQ;
        end
        return GW'(sum);
    endfunction

    assign in_burst = (state_q == BURST);
    assign next_ptr = (grant_q == LAST_REQ) ? '0 : grant_q + GW'(1);

    // Round-robin search: scanning offsets downward leaves the lowest valid offset from rr_ptr.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        any_valid = 1'b0;
        winner    = '0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            if (bus.req_valid[rr_index(rr_ptr_q, off)]) begin
                any_valid = 1'b1;
                winner    = rr_index(rr_ptr_q, off);
            end
        end
    end

    // Select the granted requester's valid and data, and drive the handshake outputs.
    always_comb begin
        grant_valid      = 1'b0;
        grant_data       = '0;
        bus.req_ready    = '0;
        bus.fifo_push    = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q == GW'(i)) begin
                grant_valid = bus.req_valid[i];
                grant_data  = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        bus.fifo_data_in = grant_data;
        if (!rst && in_burst) begin
            for (int i = 0; i < N_REQ; i++) begin
                bus.req_ready[i] = (grant_q == GW'(i)) && !bus.fifo_full;
            end
            bus.fifo_push = grant_valid && !bus.fifo_full;
        end
    end

    // Next-state logic: arbitrate in IDLE, count beats and release the grant in BURST.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        beat_d   = beat_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    grant_d = winner;
                    beat_d  = '0;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (!grant_valid) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_ptr;
                end else if (!bus.fifo_full) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d  = IDLE;
                        rr_ptr_d = next_ptr;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, grant, pointer, beat and push-counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            beat_q     <= '0;
            push_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            beat_q   <= beat_d;
            if (bus.fifo_push) begin
                push_cnt_q <= push_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    assign grant_id   = grant_q;
    assign busy       = in_burst;
    assign push_count = push_cnt_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter. Requesters are per-index word
// queues; a transaction-level reference model predicts each push (who and
// what), a monitor compares every DUT push against the scoreboard queue.
// A second instance with a 4-bit counter shadows the first for wrap checks.
module tb_fifo_wr_arbiter;

    localparam int N_REQ      = 4;
    localparam int DATA_WIDTH = 8;
    localparam int MAX_BURST  = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.N_REQ(N_REQ), .DATA_WIDTH(DATA_WIDTH)) bus ();
    fifo_wr_arbiter_if #(.N_REQ(N_REQ), .DATA_WIDTH(DATA_WIDTH)) bus_w ();

    assign bus_w.req_valid = bus.req_valid;
    assign bus_w.req_data  = bus.req_data;
    assign bus_w.fifo_full = bus.fifo_full;

    logic [1:0]  grant_id, grant_id_w;
    logic        busy, busy_w;
    logic [15:0] push_count;
    logic [3:0]  push_count_w;

    fifo_wr_arbiter #(.N_REQ(N_REQ), .DATA_WIDTH(DATA_WIDTH), .MAX_BURST(MAX_BURST), .CNT_WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .grant_id   (grant_id),
        .busy       (busy),
        .push_count (push_count)
    );

    fifo_wr_arbiter #(.N_REQ(N_REQ), .DATA_WIDTH(DATA_WIDTH), .MAX_BURST(MAX_BURST), .CNT_WIDTH(4)) dut_w (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus_w),
        .grant_id   (grant_id_w),
        .busy       (busy_w),
        .push_count (push_count_w)
    );

    typedef struct {
        int        who;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] src_q[N_REQ][$];
    logic [7:0] push_log[$];

    int total = 0;
    int bad   = 0;

    // Reference model: owner<0 means arbitrating this cycle.
    int m_owner = -1;
    int m_beats = 0;
    int m_ptr   = 0;
    int m_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail(input string name, input int act, input int req);
        total++;
        bad++;
        $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    endtask

    // One cycle of the arbitration rules applied to this cycle's inputs.
    task automatic model_step(input logic [N_REQ-1:0] v, input logic full, input logic r,
                              output bit push, output int who);
        bit found;
        push  = 1'b0;
        who   = -1;
        found = 1'b0;
        if (r) begin
            m_owner = -1;
            m_beats = 0;
            m_ptr   = 0;
            m_count = 0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (!found && v[(m_ptr + k) % N_REQ]) begin
                    found   = 1'b1;
                    m_owner = (m_ptr + k) % N_REQ;
                    m_beats = 0;
                end
            end
        end else if (!v[m_owner]) begin
            m_ptr   = (m_owner + 1) % N_REQ;
            m_owner = -1;
        end else if (!full) begin
            push = 1'b1;
            who  = m_owner;
            m_count++;
            m_beats++;
            if (m_beats == MAX_BURST) begin
                m_ptr   = (m_owner + 1) % N_REQ;
                m_owner = -1;
            end
        end
    endtask

    // Drive one cycle's inputs at the falling edge and record the predicted push.
    task automatic drive_cycle(input logic [N_REQ-1:0] en, input logic full, input logic r);
        logic [N_REQ-1:0]            v;
        logic [N_REQ*DATA_WIDTH-1:0] d;
        bit                          push;
        int                          who;
        @(negedge clk);
        v = '0;
        d = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (en[i] && src_q[i].size() > 0) begin
                v[i] = 1'b1;
                d[i*DATA_WIDTH +: DATA_WIDTH] = src_q[i][0];
            end
        end
        bus.req_valid = v;
        bus.req_data  = d;
        bus.fifo_full = full;
        rst           = r;
        model_step(v, full, r, push, who);
        if (push) begin
            exp_q.push_back('{who, src_q[who][0]});
            void'(src_q[who].pop_front());
        end
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic do_reset();
        for (int i = 0; i < N_REQ; i++) src_q[i].delete();
        drive_cycle('0, 1'b0, 1'b1);
        drive_cycle('0, 1'b0, 1'b1);
        push_log.delete();
    endtask

    // Monitor: pops the scoreboard on every DUT push; a predicted push with no DUT push is flagged.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (bus.fifo_push === 1'b1) begin
                check("push_while_full", 32'(bus.fifo_full), 32'd0);
                push_log.push_back(bus.fifo_data_in);
                if (exp_q.size() == 0) begin
                    fail("unexpected_push", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("push_grant", 32'(grant_id), 32'(e.who));
                    check("push_data", 32'(bus.fifo_data_in), 32'(e.data));
                end
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                fail("missing_push", 0, 1);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int guard;
        int stall;
        int n2;
        logic f;

        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.fifo_full = 1'b0;

        // Reset state
        do_reset();
        drive_cycle('0, 1'b0, 1'b0);
        settle();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant", 32'(grant_id), 32'd0);
        check("rst_count", 32'(push_count), 32'd0);
        check("rst_ready", 32'(bus.req_ready), 32'd0);
        check("rst_push", 32'(bus.fifo_push), 32'd0);

        // T1: single requester, six words -> bursts of 4 then 2
        do_reset();
        for (int i = 0; i < 6; i++) src_q[0].push_back(8'(8'h10 + i));
        drive_cycle(4'b0001, 1'b0, 1'b0);
        settle();
        check("t1_idle_push", 32'(bus.fifo_push), 32'd0);
        drive_cycle(4'b0001, 1'b0, 1'b0);
        settle();
        check("t1_first_push", 32'(bus.fifo_push), 32'd1);
        check("t1_first_busy", 32'(busy), 32'd1);
        for (int c = 0; c < 10; c++) drive_cycle(4'b0001, 1'b0, 1'b0);
        settle();
        check("t1_count", 32'(push_count), 32'd6);
        check("t1_log_size", 32'(push_log.size()), 32'd6);
        for (int i = 0; i < push_log.size() && i < 6; i++)
            check("t1_order", 32'(push_log[i]), 32'(8'h10 + i));

        // T2: all four valid -> grant order 0,1,2,3,0
        do_reset();
        for (int i = 0; i < N_REQ; i++)
            for (int b = 0; b < ((i == 0) ? 8 : 4); b++)
                src_q[i].push_back(8'(8'hA0 + 16 * i + b));
        for (int c = 0; c < 21; c++) drive_cycle(4'b1111, 1'b0, 1'b0);
        settle();
        check("t2_count16", 32'(push_count), 32'd16);
        check("t2_idle_between", 32'(busy), 32'd0);
        drive_cycle(4'b1111, 1'b0, 1'b0);
        settle();
        check("t2_wrap_grant", 32'(grant_id), 32'd0);
        for (int c = 0; c < 10; c++) drive_cycle(4'b1111, 1'b0, 1'b0);
        settle();
        check("t2_log_size", 32'(push_log.size()), 32'd20);
        if (push_log.size() >= 17) begin
            check("t2_burst1", 32'(push_log[4]), 32'h00B0);
            check("t2_burst2", 32'(push_log[8]), 32'h00C0);
            check("t2_burst3", 32'(push_log[12]), 32'h00D0);
            check("t2_burst4", 32'(push_log[16]), 32'h00A4);
        end

        // T3: FIFO full for 3 cycles after the second word of req1
        do_reset();
        for (int i = 0; i < 4; i++) src_q[1].push_back(8'(8'h31 + i));
        stall = 0;
        for (int c = 0; c < 16; c++) begin
            f = (m_count == 2 && stall < 3);
            drive_cycle(4'b0010, f, 1'b0);
            settle();
            if (f) begin
                stall++;
                check("t3_stall_ready", 32'(bus.req_ready), 32'd0);
                check("t3_stall_push", 32'(bus.fifo_push), 32'd0);
            end
        end
        check("t3_count", 32'(push_count), 32'd4);
        check("t3_log_size", 32'(push_log.size()), 32'd4);
        for (int i = 0; i < push_log.size() && i < 4; i++)
            check("t3_order", 32'(push_log[i]), 32'(8'h31 + i));

        // T4: req2 drops valid after 2 words while req3 waits
        do_reset();
        for (int i = 0; i < 4; i++) begin
            src_q[2].push_back(8'(8'h21 + i));
            src_q[3].push_back(8'(8'h41 + i));
        end
        guard = 0;
        while (m_count < 2 && guard < 20) begin
            drive_cycle(4'b1100, 1'b0, 1'b0);
            guard++;
        end
        if (guard >= 20) fail("t4_bound", guard, 20);
        drive_cycle(4'b1000, 1'b0, 1'b0);
        settle();
        check("t4_drop_push", 32'(bus.fifo_push), 32'd0);
        drive_cycle(4'b1000, 1'b0, 1'b0);
        settle();
        check("t4_idle", 32'(busy), 32'd0);
        drive_cycle(4'b1000, 1'b0, 1'b0);
        settle();
        check("t4_grant3", 32'(grant_id), 32'd3);
        check("t4_busy", 32'(busy), 32'd1);
        for (int c = 0; c < 8; c++) drive_cycle(4'b1000, 1'b0, 1'b0);
        settle();
        n2 = 0;
        foreach (push_log[i]) if (push_log[i][7:4] == 4'h2) n2++;
        check("t4_req2_words", 32'(n2), 32'd2);
        check("t4_count", 32'(push_count), 32'd6);

        // T5: reset during the third beat of a req0 burst
        do_reset();
        for (int i = 0; i < 8; i++) src_q[0].push_back(8'(8'h51 + i));
        for (int i = 0; i < 4; i++) src_q[1].push_back(8'(8'h61 + i));
        guard = 0;
        while (m_count < 2 && guard < 20) begin
            drive_cycle(4'b0011, 1'b0, 1'b0);
            guard++;
        end
        if (guard >= 20) fail("t5_bound", guard, 20);
        drive_cycle(4'b0011, 1'b0, 1'b1);
        settle();
        check("t5_rst_push", 32'(bus.fifo_push), 32'd0);
        check("t5_rst_ready", 32'(bus.req_ready), 32'd0);
        drive_cycle(4'b0011, 1'b0, 1'b0);
        settle();
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_count", 32'(push_count), 32'd0);
        drive_cycle(4'b0011, 1'b0, 1'b0);
        settle();
        check("t5_grant0", 32'(grant_id), 32'd0);
        for (int c = 0; c < 30; c++) drive_cycle(4'b0011, 1'b0, 1'b0);
        settle();
        check("t5_total", 32'(push_count), 32'd10);

        // T6: 17 single-word transfers; the 4-bit counter wraps to 1
        do_reset();
        for (int k = 0; k < 17; k++) begin
            src_q[0].push_back(8'(k));
            guard = 0;
            while (src_q[0].size() > 0 && guard < 10) begin
                drive_cycle(4'b0001, 1'b0, 1'b0);
                guard++;
            end
            if (guard >= 10) fail("t6_bound", guard, 10);
        end
        drive_cycle('0, 1'b0, 1'b0);
        drive_cycle('0, 1'b0, 1'b0);
        settle();
        check("t6_count16", 32'(push_count), 32'd17);
        check("t6_count4_wrap", 32'(push_count_w), 32'd1);

        // Random traffic with random stalls and valid drops, then drain
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            logic [N_REQ-1:0] en;
            for (int i = 0; i < N_REQ; i++) begin
                if (src_q[i].size() < 6 && $urandom_range(0, 2) == 0)
                    src_q[i].push_back(8'($urandom));
                en[i] = ($urandom_range(0, 3) != 0);
            end
            drive_cycle(en, ($urandom_range(0, 4) == 0), 1'b0);
        end
        guard = 0;
        while ((src_q[0].size() + src_q[1].size() + src_q[2].size() + src_q[3].size()) > 0 && guard < 400) begin
            drive_cycle(4'b1111, 1'b0, 1'b0);
            guard++;
        end
        if (guard >= 400) fail("rand_drain_bound", guard, 400);
        drive_cycle('0, 1'b0, 1'b0);
        drive_cycle('0, 1'b0, 1'b0);
        settle();
        check("rand_count16", 32'(push_count), 32'(16'(m_count)));
        check("rand_count4", 32'(push_count_w), 32'(4'(m_count)));
        check("rand_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
